// File: rtl/zigbee_padmux_pkg.sv
// Shared types and sizing helpers for the pad-mux arbiter.
// The top level and the round-robin picker both import this package.
package zigbee_padmux_pkg;

  localparam int unsigned DEF_N_CLIENTS = 4;
  localparam int unsigned DEF_IN_W      = 22;
  localparam int unsigned DEF_OUT_W     = 18;
  localparam int unsigned SEL_W         = $clog2(DEF_N_CLIENTS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GUARD_IN = 2'd1,
    OWNED    = 2'd2,
    RELEASE  = 2'd3
  } padmux_state_e;

  // Width of a counter or index covering 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zigbee_padmux_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, modulo N.
module zigbee_padmux_rr_pick
  import zigbee_padmux_pkg::*;
#(
  parameter int unsigned N  = DEF_N_CLIENTS,
  parameter int unsigned SW = cnt_w(DEF_N_CLIENTS)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic          vld
);

  logic [SW-1:0] k;

  always_comb begin
    idx = '0;
    vld = 1'b0;
    k   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = SW'((32'(ptr) + i) % N);
      if (!vld && req[k]) begin
        vld = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/zigbee_pad_mux_arbiter.sv
// Time-shares the pad bus between N clients: round-robin pick, quiet guard
// bubbles around every ownership change, and a tenure limit under contention.
module zigbee_pad_mux_arbiter
  import zigbee_padmux_pkg::*;
#(
  parameter int unsigned N_CLIENTS    = DEF_N_CLIENTS,
  parameter int unsigned IN_W         = DEF_IN_W,
  parameter int unsigned OUT_W        = DEF_OUT_W,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned MAX_GRANT    = 256,
  localparam int unsigned SW          = cnt_w(N_CLIENTS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_CLIENTS-1:0]         req_i,
  input  logic [N_CLIENTS-1:0]         done_i,
  input  logic [N_CLIENTS*OUT_W-1:0]   cli_out_i,
  input  logic [IN_W-1:0]              pad_in_i,
  output logic [N_CLIENTS-1:0]         gnt_o,
  output logic [SW-1:0]                sel_o,
  output logic [OUT_W-1:0]             pad_out_o,
  output logic [IN_W-1:0]              cli_in_o,
  output logic [N_CLIENTS-1:0]         cli_in_vld_o,
  output logic                         busy_o
);

  localparam int unsigned GW = cnt_w(GUARD_CYCLES);
  localparam int unsigned TW = cnt_w(MAX_GRANT);

  padmux_state_e        state_q, state_d;
  logic [SW-1:0]        sel_q, sel_d, rr_q, rr_d, pick_idx, next_ptr;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [N_CLIENTS-1:0] gnt_q, gnt_d, owner_oh;
  logic [OUT_W-1:0]     pad_q, pad_d, owner_data;
  logic [IN_W-1:0]      cli_in_q;
  logic                 busy_q, pick_vld, tenure_max, owner_release;

  zigbee_padmux_rr_pick #(.N(N_CLIENTS), .SW(SW)) u_pick (
    .req (req_i),
    .ptr (rr_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign owner_oh      = N_CLIENTS'(1) << sel_q;
  assign next_ptr      = (sel_q == SW'(N_CLIENTS - 1)) ? '0 : sel_q + SW'(1);
  assign tenure_max    = (tcnt_q == TW'(MAX_GRANT - 1));
  // Every release cause folds into one event, so the pointer moves once.
  assign owner_release = done_i[sel_q] || !req_i[sel_q] ||
                         (tenure_max && |(req_i & ~owner_oh));

  always_comb begin
    owner_data = '0;
    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
      if (sel_q == SW'(k)) owner_data = cli_out_i[k*OUT_W +: OUT_W];
    end
  end

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gcnt_d  = gcnt_q;
    tcnt_d  = tcnt_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    pad_d   = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GUARD_IN;
          sel_d   = pick_idx;
          gcnt_d  = GW'(GUARD_CYCLES - 1);
        end
      end
      GUARD_IN: begin
        if (!req_i[sel_q]) begin
          state_d = RELEASE;
          gcnt_d  = GW'(GUARD_CYCLES - 1);
          rr_d    = next_ptr;
        end else if (gcnt_q == '0) begin
          state_d = OWNED;
          tcnt_d  = '0;
          gnt_d   = owner_oh;
        end else begin
          gcnt_d  = gcnt_q - GW'(1);
        end
      end
      OWNED: begin
        if (owner_release) begin
          state_d = RELEASE;
          gcnt_d  = GW'(GUARD_CYCLES - 1);
          rr_d    = next_ptr;
        end else begin
          gnt_d   = owner_oh;
          pad_d   = owner_data;
          if (!tenure_max) tcnt_d = tcnt_q + TW'(1);
        end
      end
      RELEASE: begin
        if (gcnt_q == '0) state_d = IDLE;
        else              gcnt_d  = gcnt_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      gcnt_q   <= '0;
      tcnt_q   <= '0;
      rr_q     <= '0;
      gnt_q    <= '0;
      pad_q    <= '0;
      cli_in_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      gcnt_q   <= gcnt_d;
      tcnt_q   <= tcnt_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      pad_q    <= pad_d;
      cli_in_q <= pad_in_i;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign gnt_o        = gnt_q;
  assign cli_in_vld_o = gnt_q;
  assign sel_o        = sel_q;
  assign pad_out_o    = pad_q;
  assign cli_in_o     = cli_in_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_zigbee_pad_mux_arbiter.sv
// Scoreboard bench for zigbee_pad_mux_arbiter: expected tenures are queued by
// the stimulus and checked by a negedge monitor as grants rise and fall.
module tb_zigbee_pad_mux_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned IN_W  = 22;
  localparam int unsigned OUT_W = 18;
  localparam int unsigned G     = 2;
  localparam int unsigned MG    = 8;
  localparam int          BOUND = 64;

  typedef struct {
    logic [N-1:0] gnt;
    logic [1:0]   sel;
    int           gap;   // -1: not checked
    int           len;   // -1: not checked
  } exp_t;

  logic               clk, rst;
  logic [N-1:0]       req, done;
  logic [N*OUT_W-1:0] cli_out;
  logic [IN_W-1:0]    pad_in;
  logic [N-1:0]       gnt_o, cli_in_vld_o;
  logic [1:0]         sel_o;
  logic [OUT_W-1:0]   pad_out_o;
  logic [IN_W-1:0]    cli_in_o;
  logic               busy_o;

  logic [OUT_W-1:0] cli_data [N];
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  zigbee_pad_mux_arbiter #(
    .N_CLIENTS(N), .IN_W(IN_W), .OUT_W(OUT_W), .GUARD_CYCLES(G), .MAX_GRANT(MG)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done), .cli_out_i(cli_out),
    .pad_in_i(pad_in), .gnt_o(gnt_o), .sel_o(sel_o), .pad_out_o(pad_out_o),
    .cli_in_o(cli_in_o), .cli_in_vld_o(cli_in_vld_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cli_out = {cli_data[3], cli_data[2], cli_data[1], cli_data[0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [N-1:0] g, input logic [1:0] s, input int gap, input int len);
    exp_t e;
    e.gnt = g; e.sel = s; e.gap = gap; e.len = len;
    q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic [N-1:0]    prev_gnt, cur_gnt;
  logic [1:0]      cur_sel;
  logic [IN_W-1:0] prev_pad;
  logic [OUT_W-1:0] exp_pad;
  bit in_grant = 0, have_prev = 0;
  int cur_len = 0, cur_gap = 0, gap_cnt = 0;

  function automatic int oh_idx(input logic [N-1:0] oh);
    int r = 0;
    for (int i = 0; i < int'(N); i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic pop_cmp(input bit by_rst);
    exp_t e;
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_grant: got %0h expected none", cur_gnt);
    end else begin
      e = q.pop_front();
      chk("grant_vec", 32'(cur_gnt), 32'(e.gnt));
      chk("grant_sel", 32'(cur_sel), 32'(e.sel));
      if (e.gap >= 0) chk("guard_gap", cur_gap, e.gap);
      if (!by_rst && e.len >= 0) chk("tenure_len", cur_len, e.len);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (in_grant) pop_cmp(1'b1);
      in_grant = 0; have_prev = 0; gap_cnt = 0; prev_gnt = '0;
    end else begin
      if (have_prev) chk("cli_in_delay", 32'(cli_in_o), 32'(prev_pad));
      prev_pad = pad_in; have_prev = 1;
      exp_pad = (gnt_o != '0 && gnt_o == prev_gnt) ? cli_data[oh_idx(gnt_o)] : '0;
      chk("pad_out", 32'(pad_out_o), 32'(exp_pad));
      if (gnt_o != '0) begin
        if (!in_grant) begin
          in_grant = 1; cur_gnt = gnt_o; cur_sel = sel_o; cur_len = 1; cur_gap = gap_cnt;
        end else begin
          if (gnt_o != cur_gnt) chk("grant_stable", 32'(gnt_o), 32'(cur_gnt));
          cur_len++;
        end
      end else if (in_grant) begin
        pop_cmp(1'b0);
        in_grant = 0; gap_cnt = 1;
      end else begin
        gap_cnt++;
      end
      prev_gnt = gnt_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk); #1;
    pad_in = IN_W'($urandom);
  endtask

  task automatic reset_dut;
    rst = 1'b1; req = '0; done = '0;
    tick; tick;
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_sel", 32'(sel_o), 0);
    chk("rst_pad_out", 32'(pad_out_o), 0);
    chk("rst_cli_in", 32'(cli_in_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst = 1'b0;
  endtask

  task automatic wait_gnt;
    int n = 0;
    while (gnt_o == '0 && n < BOUND) begin tick; n++; end
    if (gnt_o == '0) begin
      checks++; errors++;
      $display("FAIL wait_grant: got none expected a grant within %0d cycles", BOUND);
    end
  endtask

  task automatic wait_nognt;
    int n = 0;
    while (gnt_o != '0 && n < BOUND) begin tick; n++; end
    if (gnt_o != '0) begin
      checks++; errors++;
      $display("FAIL wait_release: got %0h expected 0 within %0d cycles", gnt_o, BOUND);
    end
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy_o && n < BOUND) begin tick; n++; end
    if (busy_o) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy expected idle within %0d cycles", BOUND);
    end
  endtask

  // Owner holds for k cycles in total, the last one carrying its done pulse.
  task automatic hold_done(input int k);
    repeat (k - 1) tick;
    done = gnt_o;
    tick;
    done = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; done = '0; pad_in = '0;
    cli_data[0] = 18'h11111; cli_data[1] = 18'h22222;
    cli_data[2] = 18'h2A5A5; cli_data[3] = 18'h3C3C3;

    // Single request: sel at +1, grant at +3, data one cycle after grant.
    reset_dut;
    push(4'b0100, 2'd2, -1, 2);
    req = 4'b0100;
    tick;
    chk("t1_sel", 32'(sel_o), 2);
    chk("t1_gnt_guard1", 32'(gnt_o), 0);
    chk("t1_busy", 32'(busy_o), 1);
    tick;
    chk("t1_gnt_guard2", 32'(gnt_o), 0);
    tick;
    chk("t1_gnt", 32'(gnt_o), 32'h4);
    chk("t1_cli_in_vld", 32'(cli_in_vld_o), 32'h4);
    chk("t1_pad_first", 32'(pad_out_o), 0);
    tick;
    chk("t1_pad_data", 32'(pad_out_o), 32'h2A5A5);
    req = '0;
    wait_idle;

    // Round robin with all clients requesting.
    reset_dut;
    push(4'b0001, 2'd0, -1, 3);
    push(4'b0010, 2'd1, 5, 3);
    push(4'b0100, 2'd2, 5, 3);
    push(4'b1000, 2'd3, 5, 3);
    push(4'b0001, 2'd0, 5, 3);
    req = 4'b1111;
    repeat (5) begin
      wait_gnt;
      hold_done(3);
    end
    req = '0;
    wait_idle;

    // Tenure limit under contention.
    reset_dut;
    push(4'b0010, 2'd1, -1, int'(MG));
    push(4'b1000, 2'd3, 5, 2);
    req = 4'b0010;
    wait_gnt;
    req = 4'b1010;
    wait_nognt;
    req = 4'b1000;
    wait_gnt;
    hold_done(2);
    req = '0;
    wait_idle;

    // Abort in GUARD_IN, then the pointer has moved past the aborted client.
    reset_dut;
    req = 4'b0001;
    tick;
    chk("t4_sel", 32'(sel_o), 0);
    req = '0;
    tick;
    chk("t4_gnt_rel1", 32'(gnt_o), 0);
    chk("t4_busy_rel1", 32'(busy_o), 1);
    tick;
    chk("t4_gnt_rel2", 32'(gnt_o), 0);
    chk("t4_busy_rel2", 32'(busy_o), 1);
    tick;
    chk("t4_gnt_idle", 32'(gnt_o), 0);
    chk("t4_busy_idle", 32'(busy_o), 0);
    push(4'b0010, 2'd1, -1, 2);
    req = 4'b0011;
    wait_gnt;
    hold_done(2);
    req = '0;
    wait_idle;

    // done and tenure limit in the same cycle advance the pointer once.
    reset_dut;
    push(4'b0001, 2'd0, -1, int'(MG));
    push(4'b0010, 2'd1, 5, 2);
    req = 4'b0001;
    wait_gnt;
    req = 4'b0111;
    hold_done(int'(MG));
    req = 4'b0110;
    wait_gnt;
    hold_done(2);
    req = '0;
    wait_idle;

    // Asynchronous reset in the middle of a tenure.
    reset_dut;
    push(4'b0100, 2'd2, -1, -1);
    req = 4'b0100;
    wait_gnt;
    tick;
    #2 rst = 1'b1;
    #1;
    chk("t6_gnt_async", 32'(gnt_o), 0);
    chk("t6_pad_async", 32'(pad_out_o), 0);
    chk("t6_sel_async", 32'(sel_o), 0);
    chk("t6_busy_async", 32'(busy_o), 0);
    req = 4'b1111;
    push(4'b0001, 2'd0, -1, 2);
    tick;
    rst = 1'b0;
    wait_gnt;
    hold_done(2);
    req = '0;
    wait_idle;

    tick; tick;
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
